noc_rx_credit_buffer: RTL and testbench

Receiver-side input buffer for a NoC router port. It is the downstream end of the credit-based link whose upstream end is the flow control unit (fcu). It stores incoming flits in a FIFO, presents them to the router's switch stage with a valid/ready handshake, and returns one credit pulse to the upstream fcu per freed slot. After reset it also issues DEPTH initial credits, so the upstream credit counter starts at zero.

---
 rtl/noc_rx_credit_buffer.sv | 95 +++++++++
 tb/tb_noc_rx_credit_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/noc_rx_credit_buffer.sv
// noc_rx_credit_buffer
// Receiver-side flit FIFO for a credit-based NoC link. It buffers incoming
// flits, presents the head flit to the switch stage with valid/ready, and
// returns one credit pulse upstream per freed slot. After reset it issues
// DEPTH initial credits.
module noc_rx_credit_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] flit_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] flit_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              credit_out,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   pend_q, pend_d;
  logic [ADDR_W:0]   pend_eff;
  logic              credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic              full, not_empty, push, pop;

  // Handshake decode; everything here depends only on registers plus inputs
  // that feed next-state logic, never an output.
  always_comb begin
    full      = (count_q == DEPTH_C);
    not_empty = (count_q != '0);
    pop       = not_empty && ready_in;
    push      = valid_in && (!full || pop);
  end

  // Next-state for pointers, occupancy, sticky overflow and credit return.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + ONE_C;
    if (pop && !push) count_d = count_q - ONE_C;
    // A push into a full FIFO with no pop is dropped and flagged.
    overflow_d = overflow_q | (valid_in & full & ~pop);
    // Freed slots queue in pend; at most one credit leaves per cycle, so a
    // pop during the initial burst lengthens it rather than merging.
    pend_eff   = pend_q + {{ADDR_W{1'b0}}, pop};
    credit_d   = (pend_eff != '0);
    pend_d     = pend_eff - {{ADDR_W{1'b0}}, credit_d};
  end

  // Control state with asynchronous reset; reset reloads the initial credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= DEPTH_C;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Flit storage; data is not reset, only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_in;
  end

  // Head flit is masked while empty so the output reads 0 out of reset
  // without having to clear the storage array.
  always_comb begin
    flit_out   = not_empty ? mem_q[rd_ptr_q] : '0;
    valid_out  = not_empty;
    credit_out = credit_q;
    count      = count_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_noc_rx_credit_buffer.sv
// Directed bench for noc_rx_credit_buffer (DEPTH=4, DATA_W=32).
module tb_noc_rx_credit_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] flit_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] flit_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        credit_out;
  logic [2:0]  count;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  noc_rx_credit_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flit_in    (flit_in),
    .valid_in   (valid_in),
    .flit_out   (flit_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .credit_out (credit_out),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vin;
    logic [31:0] din;
    logic        rdy;
    logic        e_vout;
    logic [31:0] e_dout;
    logic        e_cred;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic v, input logic [31:0] d, input logic y,
                     input logic ev, input logic [31:0] ed, input logic ec,
                     input int en, input logic eo);
    vec_t x;
    x.rst = r; x.vin = v; x.din = d; x.rdy = y;
    x.e_vout = ev; x.e_dout = ed; x.e_cred = ec; x.e_cnt = 3'(en); x.e_ovf = eo;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_cleared(input int idx);
    chk("rst_flit_out", idx, flit_out, 32'h0);
    chk("rst_valid_out", idx, 32'(valid_out), 32'h0);
    chk("rst_count", idx, 32'(count), 32'h0);
    chk("rst_credit_out", idx, 32'(credit_out), 32'h0);
    chk("rst_overflow", idx, 32'(overflow), 32'h0);
  endtask

  initial begin
    int ncred;

    // Reset held 3 cycles, then the initial 4-credit burst.
    for (int i = 0; i < 3; i++) row(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) row(0, 0, 0, 0, 0, 0, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill A0..A3, then drain in order with one credit per pop.
    for (int i = 0; i < 4; i++) row(0, 1, 32'hA0 + 32'(i), 0, 1, 32'hA0, 0, i + 1, 0);
    row(0, 0, 0, 1, 1, 32'hA1, 1, 3, 0);
    row(0, 0, 0, 1, 1, 32'hA2, 1, 2, 0);
    row(0, 0, 0, 1, 1, 32'hA3, 1, 1, 0);
    row(0, 0, 0, 1, 0, 0, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Full with simultaneous push and pop: no overflow, B4 after B1..B3.
    for (int i = 0; i < 4; i++) row(0, 1, 32'hB0 + 32'(i), 0, 1, 32'hB0, 0, i + 1, 0);
    row(0, 1, 32'hB4, 1, 1, 32'hB1, 1, 4, 0);
    row(0, 0, 0, 1, 1, 32'hB2, 1, 3, 0);
    row(0, 0, 0, 1, 1, 32'hB3, 1, 2, 0);
    row(0, 0, 0, 1, 1, 32'hB4, 1, 1, 0);
    row(0, 0, 0, 1, 0, 0, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Streaming 1..20 with pointer wrap: count holds at 1, credit every cycle.
    row(0, 1, 1, 1, 1, 1, 0, 1, 0);
    for (int k = 2; k <= 20; k++) row(0, 1, 32'(k), 1, 1, 32'(k), 1, 1, 0);
    row(0, 0, 0, 1, 0, 0, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Overflow: 0xDEAD dropped, flag sticky, only C0..C3 drain.
    for (int i = 0; i < 4; i++) row(0, 1, 32'hC0 + 32'(i), 0, 1, 32'hC0, 0, i + 1, 0);
    row(0, 1, 32'hDEAD, 0, 1, 32'hC0, 0, 4, 1);
    row(0, 0, 0, 0, 1, 32'hC0, 0, 4, 1);
    row(0, 0, 0, 1, 1, 32'hC1, 1, 3, 1);
    row(0, 0, 0, 1, 1, 32'hC2, 1, 2, 1);
    row(0, 0, 0, 1, 1, 32'hC3, 1, 1, 1);
    row(0, 0, 0, 1, 0, 0, 1, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; valid_in = tbl[i].vin; flit_in = tbl[i].din; ready_in = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk("valid_out", i, 32'(valid_out), 32'(tbl[i].e_vout));
      if (tbl[i].e_vout || tbl[i].rst) chk("flit_out", i, flit_out, tbl[i].e_dout);
      chk("credit_out", i, 32'(credit_out), 32'(tbl[i].e_cred));
      chk("count", i, 32'(count), 32'(tbl[i].e_cnt));
      chk("overflow", i, 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Asynchronous reset clears the sticky overflow without a clock edge.
    @(negedge clk);
    valid_in = 1'b0; ready_in = 1'b0;
    rst = 1'b1;
    #1;
    chk_cleared(100);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b1; flit_in = 32'hD1;
    @(posedge clk);
    #1;
    chk("burst_count1", 101, 32'(count), 32'h1);
    chk("burst_credit1", 101, 32'(credit_out), 32'h1);
    @(negedge clk);
    flit_in = 32'hD2;
    @(negedge clk);
    flit_in = 32'hD3;
    @(posedge clk);
    #1;
    chk("mid_count", 102, 32'(count), 32'h3);
    chk("mid_flit_out", 102, flit_out, 32'hD1);
    chk("mid_credit_out", 102, 32'(credit_out), 32'h1);

    // Reset mid-operation with stored flits and credits still pending.
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk_cleared(103);
    @(negedge clk);
    rst = 1'b0;
    ncred = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_credit", 110 + i, 32'(credit_out), (i < 4) ? 32'h1 : 32'h0);
      chk("post_rst_valid", 110 + i, 32'(valid_out), 32'h0);
      if (credit_out === 1'b1) ncred++;
    end
    chk("post_rst_credit_total", 120, 32'(ncred), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
